// File: rtl/input_mem_pingpong_skew_if.sv
// -----------------------------------------------------------------------------
// input_mem_pingpong_skew_if
// Bus bundle for the ping-pong input buffer that feeds the systolic array.
//
// Handshake semantics (the same rule applies to every request/response pair):
//   - The write beat transfers on a rising clk edge where wr_valid && wr_ready.
//     wr_valid seen while wr_ready=0 is dropped, not held pending.
//   - wr_commit is a level-sampled request that only takes effect while the
//     write side is filling (wr_ready=1).
//   - rd_start is honoured only on an edge where rd_ready=1. Otherwise it is
//     ignored. rd_done and rd_err are single-cycle pulses.
//
// Signals:
//   wr_valid, wr_row_mask, wr_addr, wr_data, wr_commit : write port (master->slave)
//   wr_ready                                           : write buffer is filling
//   rd_start, rd_len                                   : stream request
//   rd_ready, rd_busy, rd_done, rd_err                 : sequencer status
//   out_valid, out_data                                : skewed per-row stream
//   dbg_seq_state                                      : sequencer FSM state
// -----------------------------------------------------------------------------
interface input_mem_pingpong_skew_if #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH)
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [SYS_ROW-1:0]            wr_row_mask;
  logic [ADDR_W-1:0]             wr_addr;
  logic [SYS_ROW*DATA_WIDTH-1:0] wr_data;
  logic                          wr_commit;
  logic                          rd_start;
  logic [ADDR_W:0]               rd_len;
  logic                          rd_ready;
  logic                          rd_busy;
  logic                          rd_done;
  logic                          rd_err;
  logic [SYS_ROW-1:0]            out_valid;
  logic [SYS_ROW*DATA_WIDTH-1:0] out_data;
  logic [1:0]                    dbg_seq_state;

  modport slave (
    input  wr_valid, wr_row_mask, wr_addr, wr_data, wr_commit, rd_start, rd_len,
    output wr_ready, rd_ready, rd_busy, rd_done, rd_err, out_valid, out_data,
           dbg_seq_state
  );

  modport master (
    output wr_valid, wr_row_mask, wr_addr, wr_data, wr_commit, rd_start, rd_len,
    input  wr_ready, rd_ready, rd_busy, rd_done, rd_err, out_valid, out_data,
           dbg_seq_state
  );
endinterface

// File: rtl/input_mem_pingpong_skew.sv
// -----------------------------------------------------------------------------
// input_mem_pingpong_skew
// Double-buffered input memory for the systolic array. A DMA-side write port
// fills one bank set while a read sequencer streams the other set into the
// array rows. Row i's stream lags row 0 by i cycles, so the array needs no
// external skew registers.
//
// Ports:
//   clk   : single clock
//   rstn  : asynchronous active-low reset (synchronous release expected)
//   bus   : input_mem_pingpong_skew_if.slave (write port, stream control,
//           skewed per-row outputs, sequencer state for debug)
//
// Buffer ownership: r_wr_sel names the write buffer, the read buffer is always
// the other one, so the two sides never touch the same storage. Bank contents
// are not reset.
// -----------------------------------------------------------------------------
module input_mem_pingpong_skew #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rstn,
  input_mem_pingpong_skew_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  localparam int CNT_W = ADDR_W + 1;
  localparam int DR_W  = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [DR_W-1:0]  C_LAST_ROW = DR_W'(SYS_ROW - 1);

  // Storage: [buffer][row][entry]
  logic [DATA_WIDTH-1:0] r_mem [2][SYS_ROW][DEPTH];

  // Buffer-level state
  logic                  r_wr_sel;
  logic                  r_wr_full;    // write side FULL (else FILLING)
  logic                  r_rd_loaded;  // read side LOADED (else EMPTY)

  // Sequencer
  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_len;
  logic [DR_W-1:0]       r_drain;
  logic                  r_done;
  logic                  r_err;

  // Per-row read pipeline
  logic [SYS_ROW-1:0]    r_out_vld;
  logic [ADDR_W-1:0]     r_ptr [SYS_ROW];
  logic [DATA_WIDTH-1:0] r_q   [SYS_ROW];

  logic                  w_wr_fire;
  logic                  w_rd_sel;
  logic                  w_rd_ready;
  logic                  w_len_bad;
  logic                  w_start;
  logic                  w_swap;
  logic [SYS_ROW-1:0]    w_iss;
  logic [SYS_ROW*DATA_WIDTH-1:0] w_out_data;

  assign w_wr_fire  = bus.wr_valid && !r_wr_full;
  assign w_rd_sel   = ~r_wr_sel;
  assign w_rd_ready = (r_state == S_IDLE) && r_rd_loaded;
  assign w_len_bad  = (bus.rd_len == '0) || (bus.rd_len > C_DEPTH);
  assign w_start    = bus.rd_start && w_rd_ready && !w_len_bad;
  // Swap needs FULL and EMPTY together; commit needs FILLING and stream end
  // needs LOADED, so none of these updates can collide on one edge.
  assign w_swap     = r_wr_full && !r_rd_loaded;

  // Row 0 issues one read per STREAM cycle. Row i repeats row i-1's issue
  // pattern one cycle later, which is exactly row i-1's registered valid.
  // Each row walks its own pointer 0,1,2,... so no address delay line is needed.
  always_comb begin
    w_iss    = '0;
    w_iss[0] = (r_state == S_STREAM);
    for (int i = 1; i < SYS_ROW; i++) begin
      w_iss[i] = r_out_vld[i-1];
    end
  end

  // Write port: masked rows keep their old contents.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int i = 0; i < SYS_ROW; i++) begin
        if (bus.wr_row_mask[i]) begin
          r_mem[r_wr_sel][i][bus.wr_addr] <= bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Bank read registers: data appears one cycle after the row issues.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SYS_ROW; i++) begin
      if (w_iss[i]) begin
        r_q[i] <= r_mem[w_rd_sel][i][r_ptr[i]];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_sel    <= 1'b0;
      r_wr_full   <= 1'b0;
      r_rd_loaded <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_drain     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_out_vld   <= '0;
      for (int i = 0; i < SYS_ROW; i++) begin
        r_ptr[i] <= '0;
      end
    end else begin
      r_done    <= 1'b0;
      r_err     <= bus.rd_start && w_rd_ready && w_len_bad;
      r_out_vld <= w_iss;

      if (bus.wr_commit && !r_wr_full) begin
        r_wr_full <= 1'b1;
      end
      if (w_swap) begin
        r_wr_sel    <= ~r_wr_sel;
        r_wr_full   <= 1'b0;
        r_rd_loaded <= 1'b1;
      end

      for (int i = 0; i < SYS_ROW; i++) begin
        if (w_start) begin
          r_ptr[i] <= '0;
        end else if (w_iss[i]) begin
          r_ptr[i] <= r_ptr[i] + ADDR_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_STREAM;
            r_cnt   <= '0;
            r_len   <= bus.rd_len;
          end
        end
        S_STREAM: begin
          if (r_cnt == r_len - CNT_W'(1)) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // Row SYS_ROW-1 trails the last issue by SYS_ROW cycles.
          if (r_drain == C_LAST_ROW) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b1;
            r_rd_loaded <= 1'b0;
          end else begin
            r_drain <= r_drain + DR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_out_data = '0;
    for (int i = 0; i < SYS_ROW; i++) begin
      if (r_out_vld[i]) begin
        w_out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_q[i];
      end
    end
  end

  assign bus.wr_ready      = !r_wr_full;
  assign bus.rd_ready      = w_rd_ready;
  assign bus.rd_busy       = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign bus.rd_done       = r_done;
  assign bus.rd_err        = r_err;
  assign bus.out_valid     = r_out_vld;
  assign bus.out_data      = w_out_data;
  assign bus.dbg_seq_state = r_state;

endmodule

// File: tb/tb_input_mem_pingpong_skew.sv
// -----------------------------------------------------------------------------
// tb_input_mem_pingpong_skew
// Directed bench for the ping-pong skewed input buffer (4 rows, 16-bit data,
// 8 entries). Expected stream contents come from the bench's own data
// patterns held in exp_tab; timing expectations are fixed cycle offsets from
// the accepted rd_start.
// -----------------------------------------------------------------------------
module tb_input_mem_pingpong_skew;

  localparam int ROWS = 4;
  localparam int DW   = 16;
  localparam int DEP  = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  input_mem_pingpong_skew_if #(.SYS_ROW(ROWS), .DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

  input_mem_pingpong_skew #(.SYS_ROW(ROWS), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_tab [ROWS][DEP];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Each step lands 1 time unit after a rising edge: outputs are settled and
  // inputs set here are sampled on the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] elem(input logic [3:0] base, input int r, input int k);
    return {base, 4'(r), 8'(k)};
  endfunction

  function automatic logic [ROWS*DW-1:0] pat(input logic [3:0] base, input int k);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = elem(base, r, k);
    return v;
  endfunction

  task automatic load_tab(input logic [3:0] base, input int n);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < n; k++) exp_tab[r][k] = elem(base, r, k);
  endtask

  task automatic wr_word(input logic [2:0] addr, input logic [3:0] mask, input logic [ROWS*DW-1:0] data);
    bus.wr_valid    = 1'b1;
    bus.wr_addr     = addr;
    bus.wr_row_mask = mask;
    bus.wr_data     = data;
    step();
    bus.wr_valid    = 1'b0;
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
  endtask

  // Called at cycle T with rd_ready=1; returns at T+len+ROWS+2.
  task automatic run_stream(input int len, input string tag);
    logic [ROWS-1:0]    ev;
    logic [ROWS*DW-1:0] ed;
    bus.rd_start = 1'b1;
    bus.rd_len   = 4'(len);
    for (int d = 1; d <= len + ROWS + 2; d++) begin
      step();
      bus.rd_start = 1'b0;
      ev = '0;
      ed = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (d >= 2 + r && d < 2 + r + len) begin
          ev[r] = 1'b1;
          ed[r*DW +: DW] = exp_tab[r][d-2-r];
        end
      end
      check($sformatf("%s/valid@T+%0d", tag, d), 64'(bus.out_valid), 64'(ev));
      check($sformatf("%s/data@T+%0d", tag, d), 64'(bus.out_data), 64'(ed));
      check($sformatf("%s/busy@T+%0d", tag, d), 64'(bus.rd_busy), 64'(d <= len + ROWS));
      check($sformatf("%s/done@T+%0d", tag, d), 64'(bus.rd_done), 64'(d == len + ROWS + 1));
    end
  endtask

  task automatic illegal_len(input int len);
    bus.rd_start = 1'b1;
    bus.rd_len   = 4'(len);
    step();
    bus.rd_start = 1'b0;
    check($sformatf("bad%0d/err", len), 64'(bus.rd_err), 64'(1));
    check($sformatf("bad%0d/ready", len), 64'(bus.rd_ready), 64'(1));
    check($sformatf("bad%0d/busy", len), 64'(bus.rd_busy), 64'(0));
    check($sformatf("bad%0d/valid", len), 64'(bus.out_valid), 64'(0));
    step();
    check($sformatf("bad%0d/err_clr", len), 64'(bus.rd_err), 64'(0));
    check($sformatf("bad%0d/valid2", len), 64'(bus.out_valid), 64'(0));
    check($sformatf("bad%0d/ready2", len), 64'(bus.rd_ready), 64'(1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int done_seen;
    int busy_seen;
    bus.wr_valid    = 1'b0;
    bus.wr_row_mask = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.wr_commit   = 1'b0;
    bus.rd_start    = 1'b0;
    bus.rd_len      = '0;
    rstn            = 1'b1;

    // Reset asserted mid-cycle: outputs must respond with no clock edge.
    step();
    step();
    #3 rstn = 1'b0;
    #1;
    check("rst/wr_ready", 64'(bus.wr_ready), 64'(1));
    check("rst/rd_ready", 64'(bus.rd_ready), 64'(0));
    check("rst/out_valid", 64'(bus.out_valid), 64'(0));
    check("rst/out_data", 64'(bus.out_data), 64'(0));
    check("rst/rd_busy", 64'(bus.rd_busy), 64'(0));
    check("rst/state", 64'(bus.dbg_seq_state), 64'(0));
    step();
    step();
    #3 rstn = 1'b1;
    step();

    // Basic stream: 4 entries, row i entry k = 16'h0i0k.
    for (int k = 0; k < 4; k++) wr_word(3'(k), 4'hF, pat(4'h0, k));
    load_tab(4'h0, 4);
    commit();
    check("basic/wr_ready_c1", 64'(bus.wr_ready), 64'(0));
    check("basic/rd_ready_c1", 64'(bus.rd_ready), 64'(0));
    step();
    check("basic/rd_ready_c2", 64'(bus.rd_ready), 64'(1));
    check("basic/wr_ready_c2", 64'(bus.wr_ready), 64'(1));
    run_stream(4, "basic");

    // Ping-pong: stream A (len 8) while filling and committing B.
    for (int k = 0; k < DEP; k++) wr_word(3'(k), 4'hF, pat(4'hA, k));
    load_tab(4'hA, DEP);
    commit();
    step();
    check("pp/a_ready", 64'(bus.rd_ready), 64'(1));
    fork
      run_stream(DEP, "pp_a");
      begin
        for (int k = 0; k < DEP; k++) wr_word(3'(k), 4'hF, pat(4'hB, k));
        commit();
        // T+9..T+14; writes offered while wr_ready=0 must be dropped.
        for (int c = 9; c <= 14; c++) begin
          check($sformatf("pp/wr_ready@T+%0d", c), 64'(bus.wr_ready), 64'(c == 14));
          check($sformatf("pp/rd_ready@T+%0d", c), 64'(bus.rd_ready), 64'(c == 14));
          bus.wr_valid    = (c < 14);
          bus.wr_addr     = 3'd0;
          bus.wr_row_mask = 4'hF;
          bus.wr_data     = {ROWS{16'hDEAD}};
          if (c < 14) step();
        end
        bus.wr_valid = 1'b0;
      end
    join
    load_tab(4'hB, DEP);
    run_stream(DEP, "pp_b");

    // Row mask, plus illegal lengths on the loaded buffer.
    wr_word(3'd0, 4'hF, {ROWS{16'h1111}});
    wr_word(3'd0, 4'b0101, {ROWS{16'hAAAA}});
    commit();
    step();
    check("mask/rd_ready", 64'(bus.rd_ready), 64'(1));
    illegal_len(0);
    illegal_len(9);
    exp_tab[0][0] = 16'hAAAA;
    exp_tab[1][0] = 16'h1111;
    exp_tab[2][0] = 16'hAAAA;
    exp_tab[3][0] = 16'h1111;
    run_stream(1, "mask");

    // Reset in the middle of a stream.
    commit();
    step();
    check("rstmid/rd_ready", 64'(bus.rd_ready), 64'(1));
    bus.rd_start = 1'b1;
    bus.rd_len   = 4'd8;
    step();
    bus.rd_start = 1'b0;
    step();
    step();
    check("rstmid/pre_valid", 64'(bus.out_valid), 64'(4'b0011));
    check("rstmid/pre_busy", 64'(bus.rd_busy), 64'(1));
    #3 rstn = 1'b0;
    #1;
    check("rstmid/valid", 64'(bus.out_valid), 64'(0));
    check("rstmid/data", 64'(bus.out_data), 64'(0));
    check("rstmid/busy", 64'(bus.rd_busy), 64'(0));
    step();
    step();
    #3 rstn = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.rd_done) done_seen++;
      if (bus.rd_busy || bus.out_valid != '0) busy_seen++;
    end
    check("rstmid/no_done", 64'(done_seen), 64'(0));
    check("rstmid/no_activity", 64'(busy_seen), 64'(0));
    check("rstmid/wr_ready", 64'(bus.wr_ready), 64'(1));
    check("rstmid/rd_ready", 64'(bus.rd_ready), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_mem_pingpong_skew.md
Name: input_mem_pingpong_skew

Overview:
- Next-generation input buffer feeding the systolic array: SYS_ROW per-row banks, parametrised depth, double-buffered (ping-pong).
- A DMA-side write port fills one bank set while a read sequencer streams the other set into the array rows.
- Read data is diagonally skewed: row i lags row 0 by i cycles, so the array needs no external skew registers.
- Bank storage is behavioural register arrays inside the block. Array contents are not reset.

Parameters:
- SYS_ROW, 16, number of array rows (banks per buffer).
- DATA_WIDTH, 16, bits per element.
- DEPTH, 256, entries per row per buffer. Must be a power of 2, ≥ 2.
- ADDR_W, $clog2(DEPTH), address width (derived).

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write buffer accepting (state FILLING).
- wr_row_mask  in  SYS_ROW  per-row write enable.
- wr_addr  in  ADDR_W  entry address.
- wr_data  in  SYS_ROW*DATA_WIDTH  row i data at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- wr_commit  in  1  marks the write buffer FULL.
- rd_start  in  1  start stream request.
- rd_len  in  ADDR_W+1  number of entries to stream.
- rd_ready  out  1  read buffer loaded and sequencer IDLE.
- rd_busy  out  1  sequencer in STREAM or DRAIN.
- rd_done  out  1  one-cycle pulse at stream end.
- rd_err  out  1  one-cycle pulse on an illegal rd_len.
- out_valid  out  SYS_ROW  per-row valid.
- out_data  out  SYS_ROW*DATA_WIDTH  per-row skewed data; zero when that row is not valid.

Behaviour:
- Reset (async assert, sync release):
  - wr_sel=0; write side FILLING; read side EMPTY; sequencer IDLE.
  - wr_ready=1; rd_ready=0; rd_busy=0; rd_done=0; rd_err=0; out_valid=0; out_data=0.
  - Reset mid-stream aborts all activity. The stream is lost; no rd_done is issued.
- Write:
  - A write occurs when wr_valid && wr_ready.
  - For each i with wr_row_mask[i]=1, buffer wr_sel, row i, entry wr_addr receives row i's slice of wr_data. Masked rows are unchanged.
  - wr_valid while wr_ready=0 is ignored; no data is written.
- Commit:
  - wr_commit while FILLING sets the write side to FULL at that edge.
  - A write in the same cycle as wr_commit is applied first.
  - wr_commit while FULL is ignored.
- Swap:
  - Occurs at any edge where the write side is FULL and the read side is EMPTY.
  - At that edge: wr_sel toggles, read side becomes LOADED, write side becomes FILLING.
  - Commit at cycle C with read side EMPTY: wr_ready=0 in C+1, swap at end of C+1, rd_ready=1 and wr_ready=1 in C+2.
- Sequencer FSM states: IDLE, STREAM, DRAIN.
  - rd_ready = IDLE && read side LOADED.
- rd_start in IDLE when rd_ready=1:
  - If rd_len==0 or rd_len>DEPTH: rd_err pulses next cycle, state stays IDLE, buffer stays LOADED.
  - Otherwise the start is accepted at cycle T and the FSM enters STREAM.
- rd_start when rd_ready=0 is ignored (no rd_err).
- STREAM: issues read address k=0..rd_len-1 at cycle T+1+k, then enters DRAIN.
- Read latency: bank read data registers one cycle after the address.
- Skew: row i presents element k with out_valid[i]=1 at cycle T+2+k+i.
- DRAIN: lasts until row SYS_ROW-1 has emitted its last element at T+rd_len+SYS_ROW.
  - rd_done pulses at T+rd_len+SYS_ROW+1.
  - At that edge the FSM returns to IDLE and the read side becomes EMPTY.
  - If the write side is already FULL, the swap follows at the next edge.
- rd_busy=1 from T+1 through T+rd_len+SYS_ROW inclusive.
- Write and read sides never address the same buffer. Writes during streaming are fully independent.
- Row i only reads its own bank. Address arithmetic is ADDR_W bits with no wrap; rd_len ≤ DEPTH guarantees this.

Test Plan:
- Reset check (SYS_ROW=4, DATA_WIDTH=16, DEPTH=8): assert rstn low mid-cycle → wr_ready=1, rd_ready=0, out_valid=4'b0000, out_data=0 immediately, without waiting for a clock edge.
- Basic stream, setup: write addr k=0..3, row i data = 16'h0i0k, mask 4'hF, then commit.
  - Check: rd_ready=1 two cycles after commit.
  - rd_start at T with len=4 → row 2 outputs 16'h0200..16'h0203 in cycles T+4..T+7.
  - rd_done at T+9; rd_busy high T+1..T+8.
- Ping-pong, setup: while stream A (len 8) runs, fill B and commit.
  - Check: wr_ready=0 until the swap one cycle after A's rd_done.
  - rd_ready=1 next cycle; second rd_start streams B's data, not A's.
- Row mask: write addr 0 with all rows 16'h1111, then with mask 4'b0101 and data 16'hAAAA → stream len 1 yields rows 0,2 = 16'hAAAA and rows 1,3 = 16'h1111.
- Illegal length: rd_len=0, then rd_len=9 → rd_err pulse each time, out_valid stays 0, rd_ready remains 1.
- Reset mid-stream at T+3 → all out_valid=0, rd_busy=0, no rd_done; after release wr_ready=1, rd_ready=0.
